// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: frame-synchronous 8-digit hex scan controller with dead time and leading-zero blanking
module seg7_scan_ctrl #(
    parameter int PRESCALE    = 100000,
    parameter int DEAD_CYCLES = 1000,
    parameter bit LZ_BLANK    = 1'b1
) (
    input  logic        clk_100,
    input  logic        reset,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        display_switch,
    input  logic [7:0]  dp_mask,
    output logic        CA,
    output logic        CB,
    output logic        CC,
    output logic        CD,
    output logic        CE,
    output logic        CF,
    output logic        CG,
    output logic        DP,
    output logic [7:0]  AN,
    output logic        frame_start
);
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] DEAD = CW'(DEAD_CYCLES);
    localparam logic [6:0] HEX [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    if (PRESCALE < 2 || DEAD_CYCLES < 0 || DEAD_CYCLES >= PRESCALE) begin : g_bad_params
        $error("seg7_scan_ctrl: need PRESCALE >= 2 and 0 <= DEAD_CYCLES < PRESCALE");
    end

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [31:0]   snap;
    logic [6:0]    seg;
    logic          boundary, wrap, blank, lit;
    logic [3:0]    nib;
    logic [7:0]    an_d;
    logic [6:0]    seg_d;
    logic          dp_d;

    // Slot decode: dead time and blanked leading zeros both leave the digit dark
    always_comb begin
        wrap     = cnt == LAST;
        boundary = cnt == '0 && idx == 3'd0;
        nib      = snap[{idx, 2'b00} +: 4];
        blank    = LZ_BLANK && idx != 3'd0 && (snap >> {idx, 2'b00}) == 32'd0;
        lit      = cnt >= DEAD && !blank;
        an_d     = lit ? ~(8'b1 << idx) : 8'hFF;
        seg_d    = lit ? HEX[nib] : 7'h7F;
        dp_d     = lit ? ~dp_mask[idx] : 1'b1;
    end

    // Counters, frame snapshot and registered pin drivers
    always_ff @(posedge clk_100) begin
        if (!reset) begin
            cnt         <= '0;
            idx         <= 3'd0;
            snap        <= 32'd0;
            AN          <= 8'hFF;
            seg         <= 7'h7F;
            DP          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            cnt         <= wrap ? '0 : cnt + 1'b1;
            idx         <= wrap ? idx + 3'd1 : idx;
            snap        <= boundary ? (display_switch ? src_b : src_a) : snap;
            AN          <= an_d;
            seg         <= seg_d;
            DP          <= dp_d;
            frame_start <= boundary;
        end
    end

    assign {CA, CB, CC, CD, CE, CF, CG} = seg;
endmodule
